// File: rtl/pipeline_pkg.sv
// Shared definitions for the image pipeline cores: the status and error
// encodings of the common start/status/err_code control contract, plus the
// pixel width used on every AXI-Stream pixel interface.
package pipeline_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_TLAST   = 2'd2
  } err_e;

endpackage

// File: rtl/sobel_window.sv
// 3x3 neighbourhood generator for the Sobel stage.
// Two W-deep line buffers hold the previous two image rows; two registered
// columns hold the previous two pixels of each of the three rows. The third
// (newest) column is formed combinationally from the line-buffer read and the
// incoming pixel, so the taps describe the window centred on the pixel that
// is W+1 positions behind the one being shifted in.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        synchronous clear of all counters (frame start)
//   i_shift        advance the window by one pixel
//   i_flush        replace the incoming pixel by zero (end-of-frame drain)
//   i_pix          incoming pixel
//   o_taps         9 window taps, index = row*3 + col, row 0 is the oldest row
//   o_out_valid    this shift produces an output pixel (pipeline is primed)
//   o_border       the output pixel produced by this shift lies on the border
//   o_last         the output pixel produced by this shift is the last of frame
module sobel_window
  import pipeline_pkg::*;
#(
  parameter int W = 512,
  parameter int H = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic                  i_flush,
  input  logic [PIX_W-1:0]      i_pix,
  output logic [8:0][PIX_W-1:0] o_taps,
  output logic                  o_out_valid,
  output logic                  o_border,
  output logic                  o_last
);

  localparam int COL_W = $clog2(W);
  localparam int ROW_W = $clog2(H);
  localparam int CNT_W = $clog2(W + 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [CNT_W-1:0] PRIMED   = CNT_W'(W + 1);

  logic [PIX_W-1:0]      r_lb0 [W];   // row r-1
  logic [PIX_W-1:0]      r_lb1 [W];   // row r-2
  logic [2:0][PIX_W-1:0] r_col0;      // oldest column, [0] = oldest row
  logic [2:0][PIX_W-1:0] r_col1;
  logic [2:0][PIX_W-1:0] w_col_new;
  logic [PIX_W-1:0]      w_pix;

  logic [COL_W-1:0] r_in_col;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic [CNT_W-1:0] r_fill;

  assign w_pix     = i_flush ? '0 : i_pix;
  assign w_col_new = {w_pix, r_lb0[r_in_col], r_lb1[r_in_col]};

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_taps = '0;
    for (int r = 0; r < 3; r++) begin
      o_taps[r*3 + 0] = r_col0[r];
      o_taps[r*3 + 1] = r_col1[r];
      o_taps[r*3 + 2] = w_col_new[r];
    end
  end

  assign o_out_valid = (r_fill == PRIMED);
  assign o_border    = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                       (r_out_col == '0) || (r_out_col == COL_LAST);
  assign o_last      = (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);

  // NOTE: pixel storage has no reset; its contents are only read once the
  // counters below prove they were written in the current frame, and leaving
  // the reset off lets the line buffers map onto RAM.
  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_lb1[r_in_col] <= r_lb0[r_in_col];
      r_lb0[r_in_col] <= w_pix;
      r_col0          <= r_col1;
      r_col1          <= w_col_new;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_col  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_fill    <= '0;
    end else if (i_clear) begin
      r_in_col  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_fill    <= '0;
    end else if (i_shift) begin
      r_in_col <= (r_in_col == COL_LAST) ? '0 : r_in_col + COL_W'(1);
      if (!o_out_valid) begin
        r_fill <= r_fill + CNT_W'(1);
      end else if (r_out_col == COL_LAST) begin
        r_out_col <= '0;
        r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + ROW_W'(1);
      end else begin
        r_out_col <= r_out_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// Sobel edge-magnitude stage. Consumes an 8-bit grayscale raster stream and
// emits |Gx| + |Gy| (saturated to 255) per pixel, with the image border
// forced to zero. Output pixel k is produced when input pixel k+W+1 is
// accepted; after the tlast beat the window drains with zero pixels.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            level; launches a frame from IDLE, DONE or ERROR
//   status           IDLE / BUSY / DONE / ERROR
//   err_code         none / timeout / tlast mismatch; held until next start
//   s_axis_*         input pixel stream (slave)
//   m_axis_*         edge-magnitude stream (master)
module sobel_edge
  import pipeline_pkg::*;
#(
  parameter int W               = 512,
  parameter int H               = 512,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
  parameter int TIME_LIMIT      = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [1:0]       status,
  output logic [1:0]       err_code,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  localparam int TIMER_W = $clog2(TIME_LIMIT + 1);
  localparam logic [TIMER_W-1:0]         TIME_LAST = TIMER_W'(TIME_LIMIT - 1);
  localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_IDX  = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

  status_e r_state, w_state_nxt;
  err_e    r_err,   w_err_nxt;

  logic [TOTAL_PIXEL_BIT-1:0] r_in_idx;
  logic [TIMER_W-1:0]         r_timer;
  logic                       r_in_done;    // tlast accepted: window is draining
  logic                       r_out_done;   // final output loaded
  logic [PIX_W-1:0]           r_mdata;
  logic                       r_mvalid;
  logic                       r_mlast;

  logic w_busy, w_enter, w_out_free, w_accept, w_flush_shift, w_shift, w_load;
  logic w_tlast_err, w_timeout, w_final_hs;

  logic [8:0][PIX_W-1:0] w_taps;
  logic                  w_win_valid, w_win_border, w_win_last;

  logic signed [10:0] w_gx, w_gy;
  logic [9:0]         w_abs_x, w_abs_y;
  logic [11:0]        w_mag;
  logic [PIX_W-1:0]   w_mag_sat;

  assign w_busy        = (r_state == ST_BUSY);
  assign w_enter       = !w_busy && start;
  assign w_out_free    = !r_mvalid || m_axis_tready;
  assign s_axis_tready = w_busy && !r_in_done && w_out_free;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_flush_shift = w_busy && r_in_done && !r_out_done && w_out_free;
  assign w_shift       = w_accept || w_flush_shift;
  assign w_load        = w_shift && w_win_valid;
  assign w_tlast_err   = w_accept && (s_axis_tlast != (r_in_idx == LAST_IDX));
  assign w_timeout     = w_busy && (r_timer == TIME_LAST);
  assign w_final_hs    = w_busy && r_mvalid && r_mlast && m_axis_tready;

  sobel_window #(
    .W (W),
    .H (H)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_enter),
    .i_shift     (w_shift),
    .i_flush     (r_in_done),
    .i_pix       (s_axis_tdata),
    .o_taps      (w_taps),
    .o_out_valid (w_win_valid),
    .o_border    (w_win_border),
    .o_last      (w_win_last)
  );

  // Zero-extend a pixel into the signed 11-bit kernel domain.
  function automatic logic signed [10:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  always_comb begin
    w_gx = ext(w_taps[2]) + (ext(w_taps[5]) <<< 1) + ext(w_taps[8])
         - ext(w_taps[0]) - (ext(w_taps[3]) <<< 1) - ext(w_taps[6]);
    w_gy = ext(w_taps[6]) + (ext(w_taps[7]) <<< 1) + ext(w_taps[8])
         - ext(w_taps[0]) - (ext(w_taps[1]) <<< 1) - ext(w_taps[2]);
    w_abs_x   = w_gx[10] ? 10'(-w_gx) : w_gx[9:0];
    w_abs_y   = w_gy[10] ? 10'(-w_gy) : w_gy[9:0];
    w_mag     = {2'b00, w_abs_x} + {2'b00, w_abs_y};
    w_mag_sat = (|w_mag[11:8]) ? 8'hFF : w_mag[7:0];
  end

  // Completion has priority over the timer; a tlast error cannot coincide
  // with completion because the final output needs all input consumed.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_BUSY: begin
        if (w_final_hs) begin
          w_state_nxt = ST_DONE;
        end else if (w_tlast_err) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = ERR_TLAST;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = ST_BUSY;
          w_err_nxt   = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_idx   <= '0;
      r_timer    <= '0;
      r_in_done  <= 1'b0;
      r_out_done <= 1'b0;
      r_mdata    <= '0;
      r_mvalid   <= 1'b0;
      r_mlast    <= 1'b0;
    end else if (w_enter) begin
      r_in_idx   <= '0;
      r_timer    <= '0;
      r_in_done  <= 1'b0;
      r_out_done <= 1'b0;
      r_mdata    <= '0;
      r_mvalid   <= 1'b0;
      r_mlast    <= 1'b0;
    end else if (w_busy) begin
      r_timer <= r_timer + TIMER_W'(1);
      if (w_accept) begin
        r_in_idx <= r_in_idx + TOTAL_PIXEL_BIT'(1);
        if (s_axis_tlast) r_in_done <= 1'b1;
      end
      if (w_tlast_err) begin
        // The frame is abandoned: nothing further leaves the core.
        r_mvalid <= 1'b0;
        r_mlast  <= 1'b0;
      end else if (w_load) begin
        r_mdata  <= w_win_border ? '0 : w_mag_sat;
        r_mvalid <= 1'b1;
        r_mlast  <= w_win_last;
        if (w_win_last) r_out_done <= 1'b1;
      end else if (m_axis_tready) begin
        r_mvalid <= 1'b0;
        r_mlast  <= 1'b0;
      end
    end
  end

  assign status       = r_state;
  assign err_code     = r_err;
  assign m_axis_tdata = r_mdata;
  assign m_axis_tvalid = r_mvalid;
  assign m_axis_tlast = r_mlast;

endmodule

// File: tb/tb_sobel_edge.sv
module tb_sobel_edge;
  import pipeline_pkg::*;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;
  localparam int TLIM = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] status, err_code;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast;
  logic       m_axis_tready = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    img[NPIX];
  int    n_vec = 0;
  int    n_err = 0;
  int    beat_cnt = 0;
  int    rdy_mode = 0;
  int    rdy_cnt = 0;

  sobel_edge #(
    .W          (W),
    .H          (H),
    .TIME_LIMIT (TLIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .status        (status),
    .err_code      (err_code),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  // Downstream ready: always on, or one cycle on / two cycles off.
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : ((rdy_cnt % 3) == 0);
  end

  // Scoreboard monitor: samples mid-cycle, so a beat seen valid&ready here
  // completes on the next rising edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, held data=%h last=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got data=%h last=%b, expected no output",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ({m_axis_tdata, m_axis_tlast} !== e) begin
            n_err++;
            $display("FAIL beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                     beat_cnt, m_axis_tdata, m_axis_tlast, e.data, e.last);
          end
          beat_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Direct 2-D reference of the edge magnitude at (r, c).
  function automatic logic [7:0] ref_out(input int r, input int c);
    int gx, gy, v, mag;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    gx = 0;
    gy = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        v  = img[(r + dr) * W + (c + dc)];
        gx += dc * ((dr == 0) ? 2 : 1) * v;
        gy += dr * ((dc == 0) ? 2 : 1) * v;
      end
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = gx + gy;
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  // kind 0: flat 100, 1: vertical step at col 4, 2: ramp 10*col
  task automatic load_frame(input int kind);
    beat_t b;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W + c] = (kind == 0) ? 100 : (kind == 1) ? ((c < 4) ? 0 : 255) : 10 * c;
    beat_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        b.data = ref_out(r, c);
        b.last = (r*W + c == NPIX - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input int tlast_at);
    bit abort;
    abort = 1'b0;
    for (int i = 0; i < n && !abort; i++) begin
      s_axis_tdata  = 8'(img[i]);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == tlast_at);
      for (int t = 0; t <= 200; t++) begin
        @(negedge clk);
        if (s_axis_tready) break;
        if (status == ST_ERROR) begin
          abort = 1'b1;
          break;
        end
        if (t == 200) begin
          n_vec++;
          n_err++;
          $display("FAIL input_stall: beat %0d not accepted within 200 cycles", i);
          abort = 1'b1;
        end
      end
      if (!abort) begin
        @(posedge clk);
        #1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_status(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (status == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_vec++; if (status !== ST_IDLE)     begin n_err++; $display("FAIL %s status: got %0d, expected 0", name, status); end
    n_vec++; if (err_code !== ERR_NONE)  begin n_err++; $display("FAIL %s err_code: got %0d, expected 0", name, err_code); end
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL %s s_tready: got %b, expected 0", name, s_axis_tready); end
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL %s m_tvalid: got %b, expected 0", name, m_axis_tvalid); end
    n_vec++; if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL %s m_tdata: got %h, expected 00", name, m_axis_tdata); end
    n_vec++; if (m_axis_tlast !== 1'b0)  begin n_err++; $display("FAIL %s m_tlast: got %b, expected 0", name, m_axis_tlast); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input string name, input int kind, input int mode);
    bit ok;
    rdy_mode = mode;
    load_frame(kind);
    do_start();
    drive_pixels(NPIX, NPIX - 1);
    wait_status(ST_DONE, 500, ok);
    n_vec++; if (!ok)                   begin n_err++; $display("FAIL %s done: got status %0d, expected 2", name, status); end
    n_vec++; if (err_code !== ERR_NONE) begin n_err++; $display("FAIL %s err_code: got %0d, expected 0", name, err_code); end
    n_vec++; if (beat_cnt != NPIX)      begin n_err++; $display("FAIL %s beats: got %0d, expected %0d", name, beat_cnt, NPIX); end
    n_vec++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL %s pending: got %0d left, expected 0", name, exp_q.size()); end
    rdy_mode = 0;
    exp_q.delete();
  endtask

  task automatic test_tlast_error();
    bit ok;
    bit any_valid;
    rdy_mode = 0;
    load_frame(2);
    do_start();
    drive_pixels(NPIX, 20);
    wait_status(ST_ERROR, 50, ok);
    n_vec++; if (!ok)                    begin n_err++; $display("FAIL tlast_err status: got %0d, expected 3", status); end
    n_vec++; if (err_code !== ERR_TLAST) begin n_err++; $display("FAIL tlast_err err_code: got %0d, expected 2", err_code); end
    exp_q.delete();
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (m_axis_tvalid || s_axis_tready) any_valid = 1'b1;
    end
    n_vec++; if (any_valid)              begin n_err++; $display("FAIL tlast_err quiet: got activity, expected tvalid=0 tready=0"); end
    test_frame("tlast_recover", 2, 0);
  endtask

  task automatic test_timeout();
    int busy;
    do_start();
    busy = 0;
    for (int i = 0; i < TLIM + 100; i++) begin
      @(negedge clk);
      if (status == ST_BUSY) busy++;
      else break;
    end
    n_vec++; if (busy != TLIM)             begin n_err++; $display("FAIL timeout busy_cycles: got %0d, expected %0d", busy, TLIM); end
    n_vec++; if (status !== ST_ERROR)      begin n_err++; $display("FAIL timeout status: got %0d, expected 3", status); end
    n_vec++; if (err_code !== ERR_TIMEOUT) begin n_err++; $display("FAIL timeout err_code: got %0d, expected 1", err_code); end
  endtask

  task automatic test_reset_midframe();
    rdy_mode = 0;
    load_frame(2);
    do_start();
    drive_pixels(30, -1);
    test_reset("midframe_reset");
    test_frame("after_reset", 1, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset("reset");
    test_frame("flat", 0, 0);
    test_frame("vstep", 1, 0);
    test_frame("ramp", 2, 0);
    test_frame("ramp_backpressure", 2, 1);
    test_tlast_error();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_edge.md
Name: sobel_edge

Overview:
- Edge-detection stage directly downstream of the Gaussian blur core; consumes its 8-bit grayscale AXI-Stream output, one pixel per beat, raster order.
- Computes the 3x3 Sobel gradient magnitude per pixel and emits a W*H 8-bit edge map on an AXI-Stream master.
- Uses the same start/status/err_code control contract as the other pipeline cores.

Parameters:
- W, 512, image width in pixels
- H, 512, image height in pixels
- TOTAL_PIXEL, W*H, pixels per frame
- TOTAL_PIXEL_BIT, $clog2(W*H), width of pixel counters
- TIME_LIMIT, 100_000_000, max cycles in BUSY before timeout error

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  level; starts a frame when state is IDLE, DONE or ERROR
- status  out  2  0=IDLE, 1=BUSY, 2=DONE, 3=ERROR
- err_code  out  2  0=none, 1=timeout, 2=tlast mismatch
- s_axis_tdata  in  8  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  core accepts input
- s_axis_tlast  in  1  asserted on last pixel of frame
- m_axis_tdata  out  8  edge magnitude
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts
- m_axis_tlast  out  1  asserted with output pixel TOTAL_PIXEL-1

Behaviour:
- Reset: status=0, err_code=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; all counters and line buffers' pointers cleared (buffer contents don't care).
- FSM IDLE -> BUSY on start=1 (status=1 the next cycle); counters and cycle timer cleared on entry. BUSY -> DONE after the output beat carrying m_axis_tlast completes. BUSY -> ERROR on a timeout or tlast mismatch. DONE/ERROR -> BUSY on start=1; err_code holds until that re-entry.
- Input: s_axis_tready = BUSY && !flush && (!m_axis_tvalid || m_axis_tready). Beats are accepted only in BUSY; a beat with tvalid while not BUSY is ignored.
- Kernels: Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1]. Each is an 11-bit signed sum.
- Magnitude: mag = |Gx| + |Gy|, 12-bit unsigned, saturated to 255.
- Border: output pixels in row 0, row H-1, column 0 and column W-1 are 0. No neighbour wrap across row ends.
- Latency: output pixel k becomes valid on the cycle after input pixel k+W+1 is accepted. The output register holds under backpressure (m_axis_tvalid high and m_axis_tready low means data, valid and last are all stable).
- Flush: after the tlast beat is accepted, flush=1, input is stalled, and the remaining W+1 outputs are emitted, one per cycle while m_axis_tready=1.
- Output count: exactly TOTAL_PIXEL beats per frame; m_axis_tlast only on the final beat.
- tlast mismatch (err 2): tlast=1 on input beat index < TOTAL_PIXEL-1, or tlast=0 on beat TOTAL_PIXEL-1. The core goes to ERROR the next cycle, drops tready and tvalid, and no further outputs are produced.
- Timeout (err 1): BUSY for TIME_LIMIT consecutive cycles leads to ERROR.
- Simultaneous events: if the final output handshake and timeout fall in the same cycle, DONE wins. Start asserted while BUSY is ignored.
- rst_n low mid-frame: immediate return to reset values; any partial frame is discarded.

Decomposition:
- Shared package (pipeline_pkg): status encodings ST_IDLE/ST_BUSY/ST_DONE/ST_ERROR, err codes ERR_NONE/ERR_TIMEOUT/ERR_TLAST, and the pixel width constant 8.
- Sub-module sobel_window: two W-deep line buffers plus a 3x3 register window with row/column counters. It outputs the 9 taps and a border flag, advances on a shift enable, and also advances during flush using zero pixels.
- Top level holds the FSM, timer, Gx/Gy/magnitude arithmetic and the output register.

Test Plan (W=8, H=8, TIME_LIMIT=1000 unless noted):
- Flat frame, all pixels 100, m_axis_tready=1 -> 64 outputs, all 0x00; tlast on beat 63 only; status=2.
- Vertical step, cols 0-3=0, cols 4-7=255 -> rows 1-6: cols 3 and 4 = 0xFF (|Gx|=1020 saturated), all other outputs 0x00.
- Horizontal ramp, pixel=10*col -> interior pixels (rows 1-6, cols 1-6) = 0x50 (Gx=80, Gy=0); borders 0x00.
- Ramp frame with m_axis_tready toggled 1 cycle on / 2 off -> output stream identical to the tready=1 run; tdata stable while stalled; 64 beats.
- tlast asserted on input beat 20 -> status=3, err_code=2; no output after the error; then start=1 with a valid frame -> status=2, err_code=0.
- start=1 with no input sent -> status=3 and err_code=1 after 1000 BUSY cycles; rst_n pulse mid-frame -> all outputs return to reset values.
